// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage sitting directly in front of Instruction_memory.
// Holds the PC, presents it as the memory byte address, and captures the
// returned little-endian word into a fetch/decode register that is handed to
// decode with a valid/ready handshake. A taken branch redirects the PC and
// flushes the held word. Fetch halts when the PC leaves the legal range.
//
// Ports
//   clk        in   1              rising-edge clock
//   reset      in   1              synchronous, active-high
//   IMEM_ADDR  out  ADDR_WIDTH     byte address to instruction memory (= PC)
//   IMEM_RD    in   BYTE_SIZE*8    word returned by memory, same cycle
//   BR_TAKEN   in   1              redirect request from execute
//   BR_TARGET  in   ADDR_WIDTH     redirect byte address (low 2 bits ignored)
//   READY_D    in   1              decode accepts the held instruction
//   VALID_D    out  1              INSTR_D / PC_D / PCPLUS8_D are valid
//   INSTR_D    out  BYTE_SIZE*8    fetched instruction
//   PC_D       out  ADDR_WIDTH     address of INSTR_D
//   PCPLUS8_D  out  ADDR_WIDTH     PC_D + 8
//   HALTED     out  1              fetch stopped, PC beyond last legal word
//   FETCH_CNT  out  32             instructions loaded into INSTR_D since reset
// ----------------------------------------------------------------------------
module fetch_stage #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    BYTE_SIZE  = 4,
    parameter int                    MEM_BYTES  = 4096,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [ADDR_WIDTH-1:0]    IMEM_ADDR,
    input  logic [BYTE_SIZE*8-1:0]   IMEM_RD,
    input  logic                     BR_TAKEN,
    input  logic [ADDR_WIDTH-1:0]    BR_TARGET,
    input  logic                     READY_D,
    output logic                     VALID_D,
    output logic [BYTE_SIZE*8-1:0]   INSTR_D,
    output logic [ADDR_WIDTH-1:0]    PC_D,
    output logic [ADDR_WIDTH-1:0]    PCPLUS8_D,
    output logic                     HALTED,
    output logic [31:0]              FETCH_CNT
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    // Range limit held one bit wider than the PC so PC+BYTE_SIZE carrying out
    // of ADDR_WIDTH is still seen as out of range instead of wrapping to 0.
    localparam logic [ADDR_WIDTH:0] C_LAST_PC = (ADDR_WIDTH+1)'(MEM_BYTES - BYTE_SIZE);
    localparam logic [ADDR_WIDTH:0] C_STEP    = (ADDR_WIDTH+1)'(BYTE_SIZE);

    state_t                   r_state;
    logic [ADDR_WIDTH-1:0]    r_pc;
    logic                     r_valid;
    logic [BYTE_SIZE*8-1:0]   r_instr;
    logic [ADDR_WIDTH-1:0]    r_pc_d;
    logic [ADDR_WIDTH-1:0]    r_pcplus8;
    logic [31:0]              r_fetch_cnt;

    logic                     w_advance;
    logic [ADDR_WIDTH:0]      w_pc_next_wide;
    logic                     w_pc_next_ok;
    logic [ADDR_WIDTH-1:0]    w_br_pc;
    logic                     w_br_ok;

    // Load a new word when the register is empty or its word leaves this cycle.
    assign w_advance      = (r_state == RUN) && (!r_valid || READY_D);

    assign w_pc_next_wide = {1'b0, r_pc} + C_STEP;
    assign w_pc_next_ok   = (w_pc_next_wide <= C_LAST_PC);

    assign w_br_pc        = {BR_TARGET[ADDR_WIDTH-1:2], 2'b00};
    assign w_br_ok        = ({1'b0, w_br_pc} <= C_LAST_PC);

    // NOTE: every register below is written with <= so all of them update from
    // the same pre-edge values; blocking assignments here would let later
    // statements see half-updated state and break simulation/synthesis match.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= RUN;
            r_pc        <= RESET_PC;
            r_valid     <= 1'b0;
            r_instr     <= '0;
            r_pc_d      <= '0;
            r_pcplus8   <= '0;
            r_fetch_cnt <= '0;
        end else if (BR_TAKEN) begin
            // Flush: the held word is dropped, nothing is captured this edge.
            r_pc    <= w_br_pc;
            r_valid <= 1'b0;
            r_state <= w_br_ok ? RUN : HALT;
        end else if (r_state == RUN) begin
            if (w_advance) begin
                r_instr     <= IMEM_RD;
                r_pc_d      <= r_pc;
                r_pcplus8   <= r_pc + ADDR_WIDTH'(8);
                r_valid     <= 1'b1;
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
                r_pc        <= w_pc_next_wide[ADDR_WIDTH-1:0];
                r_state     <= w_pc_next_ok ? RUN : HALT;
            end
            // Otherwise decode is stalling: everything holds.
        end else begin
            // HALT: PC frozen, the last captured word may still drain.
            if (r_valid && READY_D) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign IMEM_ADDR = r_pc;
    assign VALID_D   = r_valid;
    assign INSTR_D   = r_instr;
    assign PC_D      = r_pc_d;
    assign PCPLUS8_D = r_pcplus8;
    assign HALTED    = (r_state == HALT);
    assign FETCH_CNT = r_fetch_cnt;

endmodule
